rs_bank: RTL and testbench
==========================

RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clock and reset.
REQ-002 Parameter DEPTH, default 16: number of RS entries (power of two, at least 4).
REQ-003 Parameter DISP_WIDTH, default 2: dispatch ports per cycle.
REQ-004 Parameter ISSUE_WIDTH, default 2: issue ports per cycle.
REQ-005 Parameter CDB_WIDTH, default 2: CDB broadcast channels.
REQ-006 Parameter PHYS_REGS, default 128: physical register count; tag width is clog2(PHYS_REGS).
REQ-007 Parameter BR_MASK_W, default 4: number of in-flight branch-mask bits.
REQ-008 Ports SHALL be, one per entry, in this order:
- clock  in  1  rising-edge clock.
- reset  in  1  async active-low reset.
- disp_valid_i  in  DISP_WIDTH  per-port dispatch request.
- disp_pkt_i  in  DISP_WIDTH x rs_entry_t  dispatched entries (src tags, ready bits, dest tag, rob_idx, fu_type).
- disp_br_mask_i  in  DISP_WIDTH x BR_MASK_W  branches each instruction depends on.
- free_slots_o  out  clog2(DEPTH)+1  registered count of empty entries.
- cdb_valid_i  in  CDB_WIDTH  broadcast valid.
- cdb_tag_i  in  CDB_WIDTH x tag  broadcast physical tag.
- issue_valid_o  out  ISSUE_WIDTH  an issued entry is presented on the port.
- issue_pkt_o  out  ISSUE_WIDTH x rs_entry_t  the issued entry.
- issue_ready_i  in  ISSUE_WIDTH  FU accepts the port this cycle.
- br_valid_i  in  1  a branch resolves this cycle.
- br_mask_i  in  BR_MASK_W  one-hot mask of the resolving branch.
- br_mispredict_i  in  1  1 = squash dependents; 0 = clear the mask bit.

Function
REQ-009 Dispatch SHALL place accepted disp port k into the k-th lowest-indexed empty entry. Port order SHALL define age: port 0 is older than port 1.
REQ-010 Upstream SHALL never assert more disp_valid_i bits than free_slots_o; the bank SHALL flag a violation with an assertion, never by silent drop.
REQ-011 Dispatch capture SHALL OR each source ready bit with a same-cycle CDB tag match, so no wakeup is missed.
REQ-012 Each cycle, every valid entry SHALL set src ready for any CDB channel whose tag equals its source tag.
REQ-013 Ready SHALL mean valid and both source ready bits set (registered state).
REQ-014 Selection SHALL present the ISSUE_WIDTH oldest ready entries. The oldest goes to port 0, the next oldest to port 1, and so on.
REQ-015 Age SHALL be tracked by a DEPTH x DEPTH age matrix: set on dispatch, and the column cleared when the entry frees.
REQ-016 An entry SHALL free at the clock edge where issue_valid_o and issue_ready_i are both high on its port.
REQ-017 An entry that is not accepted SHALL stay and SHALL be reselected next cycle (re-ranked by age).
REQ-018 A freed entry SHALL NOT be refilled in the same cycle it frees; free_slots_o reflects the freed entry the following cycle.
REQ-019 On br_valid_i with br_mispredict_i=1:
- every entry with (br_mask AND br_mask_i) nonzero SHALL be empty next cycle;
- its issue_valid_o SHALL be suppressed combinationally that same cycle;
- a same-cycle dispatch carrying that bit SHALL be dropped.
REQ-020 On br_valid_i with br_mispredict_i=0, the br_mask_i bit SHALL be cleared in all entries and in same-cycle dispatch masks.
REQ-021 Simultaneous squash and issue acceptance of the same entry SHALL resolve as squash.
REQ-022 Base issue latency SHALL be: dispatch-ready at edge N, issue_valid_o asserted in cycle N+1.

Reset
REQ-023 While reset=0, all entries SHALL be empty, the age matrix zero, issue_valid_o=0, free_slots_o=DEPTH, and issue_pkt_o all zero.
REQ-024 Reset asserted mid-operation SHALL discard all entries immediately, regardless of clock.

Configuration
REQ-025 Macro RS_CDB_BYPASS_EN defined: ready SHALL also include same-cycle CDB hits, so an entry may issue in the broadcast cycle. Undefined: ready SHALL use registered bits only, giving issue at the earliest one cycle after broadcast.

Structure
REQ-026 rs_entry_t, the tag width, and the BR_MASK_W default SHALL live in the shared def.svh package; no local redefinition is allowed.
REQ-027 Oldest-ready selection SHALL be a sub-module rs_age_select, taking the age matrix and ready vector and producing ISSUE_WIDTH one-hot grants.

Verification
REQ-028 Dispatch two ready entries (src tags 5 and 6, both ready) with issue_ready_i=11 -> both issue next cycle; port 0 carries the port-0 dispatch; free_slots_o returns to 16.
REQ-029 Entry waiting on tag 42, CDB broadcasts 42 in cycle N -> issue_valid_o in N+1 (bypass off) or in N (bypass on).
REQ-030 Dispatch an entry waiting on tag 7 in the same cycle CDB broadcasts 7 -> the entry captures ready and issues next cycle.
REQ-031 Fill all 16 entries, then hold issue_ready_i=00 for 3 cycles -> the same oldest two stay presented; free_slots_o=0 throughout.
REQ-032 Entries with masks 0001, 0010, and 0011; mispredict with mask 0001 -> the first and third are squashed and the second is retained; free_slots_o rises by 2 next cycle.
REQ-033 Correct resolve with mask 0010 -> the second entry's mask becomes 0000; a later mispredict with mask 0010 leaves it intact.

Source files
------------

// File: rtl/rs_bank_pkg.sv
// rtl/rs_bank_pkg.sv - shared entry type, tag width and branch-mask default for the RS bank
package rs_bank_pkg;

    localparam int PHYS_REGS_DEF = 128;
    localparam int TAG_W         = $clog2(PHYS_REGS_DEF);
    localparam int BR_MASK_W_DEF = 4;
    localparam int ROB_IDX_W     = 6;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_MEM = 2'd2,
        FU_BR  = 2'd3
    } fu_type_e;

    typedef struct packed {
        logic [TAG_W-1:0]     src1_tag;
        logic                 src1_rdy;
        logic [TAG_W-1:0]     src2_tag;
        logic                 src2_rdy;
        logic [TAG_W-1:0]     dest_tag;
        logic [ROB_IDX_W-1:0] rob_idx;
        fu_type_e             fu_type;
    } rs_entry_t;

    localparam int ENTRY_W = $bits(rs_entry_t);

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - picks the ISSUE_WIDTH oldest ready entries from an age matrix
module rs_age_select #(
    parameter int DEPTH       = 16,
    parameter int ISSUE_WIDTH = 2
) (
    input  logic [DEPTH*DEPTH-1:0]       age_i,
    input  logic [DEPTH-1:0]             ready_i,
    output logic [ISSUE_WIDTH*DEPTH-1:0] grant_o
);

    // age_i row e holds a 1 for every entry older than e; the rank of a ready
    // entry among ready entries is the number of older ready entries.
    always_comb begin
        int older;
        grant_o = '0;
        for (int e = 0; e < DEPTH; e++) begin
            older = $countones(age_i[e*DEPTH +: DEPTH] & ready_i);
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (ready_i[e] && older == k) begin
                    grant_o[k*DEPTH + e] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rs_bank.sv
// rtl/rs_bank.sv - reservation station bank with age-ordered issue; RS_CDB_BYPASS_EN lets CDB hits issue same cycle
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DISP_WIDTH  = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int CDB_WIDTH   = 2,
    parameter int PHYS_REGS   = PHYS_REGS_DEF,
    parameter int BR_MASK_W   = BR_MASK_W_DEF
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [DISP_WIDTH-1:0]                  disp_valid_i,
    input  logic [DISP_WIDTH*ENTRY_W-1:0]          disp_pkt_i,
    input  logic [DISP_WIDTH*BR_MASK_W-1:0]        disp_br_mask_i,
    output logic [$clog2(DEPTH):0]                 free_slots_o,
    input  logic [CDB_WIDTH-1:0]                   cdb_valid_i,
    input  logic [CDB_WIDTH*$clog2(PHYS_REGS)-1:0] cdb_tag_i,
    output logic [ISSUE_WIDTH-1:0]                 issue_valid_o,
    output logic [ISSUE_WIDTH*ENTRY_W-1:0]         issue_pkt_o,
    input  logic [ISSUE_WIDTH-1:0]                 issue_ready_i,
    input  logic                                   br_valid_i,
    input  logic [BR_MASK_W-1:0]                   br_mask_i,
    input  logic                                   br_mispredict_i
);

    localparam int TW    = $clog2(PHYS_REGS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]            valid_q, valid_d;
    rs_entry_t                   ent_q  [DEPTH];
    rs_entry_t                   ent_d  [DEPTH];
    logic [BR_MASK_W-1:0]        mask_q [DEPTH];
    logic [BR_MASK_W-1:0]        mask_d [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
    logic [CNT_W-1:0]            free_cnt_q, free_cnt_d;

    logic [DEPTH-1:0]             hit1, hit2, squash, ready_vec, freed;
    logic [ISSUE_WIDTH*DEPTH-1:0] grant;

    function automatic logic cdb_hit(input logic [TW-1:0] tag,
                                     input logic [CDB_WIDTH-1:0] vld,
                                     input logic [CDB_WIDTH*TW-1:0] tags);
        cdb_hit = 1'b0;
        for (int c = 0; c < CDB_WIDTH; c++) begin
            if (vld[c] && tags[c*TW +: TW] == tag) cdb_hit = 1'b1;
        end
    endfunction

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            hit1[e]   = cdb_hit(ent_q[e].src1_tag, cdb_valid_i, cdb_tag_i);
            hit2[e]   = cdb_hit(ent_q[e].src2_tag, cdb_valid_i, cdb_tag_i);
            squash[e] = valid_q[e] & br_valid_i & br_mispredict_i & (|(mask_q[e] & br_mask_i));
`ifdef RS_CDB_BYPASS_EN
            ready_vec[e] = valid_q[e] & (ent_q[e].src1_rdy | hit1[e]) & (ent_q[e].src2_rdy | hit2[e]);
`else
            ready_vec[e] = valid_q[e] & ent_q[e].src1_rdy & ent_q[e].src2_rdy;
`endif
        end
    end

    rs_age_select #(
        .DEPTH       (DEPTH),
        .ISSUE_WIDTH (ISSUE_WIDTH)
    ) u_select (
        .age_i   (age_q),
        .ready_i (ready_vec),
        .grant_o (grant)
    );

    // Squash outranks acceptance: a squashed grant is never shown as valid.
    always_comb begin
        issue_valid_o = '0;
        issue_pkt_o   = '0;
        freed         = squash;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (grant[k*DEPTH + e]) begin
                    issue_valid_o[k]                  = ~squash[e];
                    issue_pkt_o[k*ENTRY_W +: ENTRY_W] = ent_q[e];
                    if (issue_ready_i[k] && !squash[e]) freed[e] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        int                   er;
        int                   pr;
        int                   erank [DEPTH];
        logic [DEPTH-1:0]     older;
        logic [BR_MASK_W-1:0] dmask;
        logic                 drop;
        rs_entry_t            pkt;

        valid_d = valid_q & ~freed;
        age_d   = age_q;
        for (int e = 0; e < DEPTH; e++) begin
            ent_d[e]          = ent_q[e];
            ent_d[e].src1_rdy = ent_q[e].src1_rdy | hit1[e];
            ent_d[e].src2_rdy = ent_q[e].src2_rdy | hit2[e];
            mask_d[e]         = mask_q[e];
            if (br_valid_i && !br_mispredict_i) mask_d[e] = mask_q[e] & ~br_mask_i;
            for (int i = 0; i < DEPTH; i++) begin
                if (freed[e]) age_d[i][e] = 1'b0;
            end
        end

        // Allocation ranks empties from the registered state, so slots freed
        // this cycle are not reused until the next one.
        er = 0;
        for (int e = 0; e < DEPTH; e++) begin
            erank[e] = er;
            if (!valid_q[e]) er++;
        end

        older = valid_q & ~freed;
        pr    = 0;
        for (int p = 0; p < DISP_WIDTH; p++) begin
            pkt          = disp_pkt_i[p*ENTRY_W +: ENTRY_W];
            pkt.src1_rdy = pkt.src1_rdy | cdb_hit(pkt.src1_tag, cdb_valid_i, cdb_tag_i);
            pkt.src2_rdy = pkt.src2_rdy | cdb_hit(pkt.src2_tag, cdb_valid_i, cdb_tag_i);
            dmask        = disp_br_mask_i[p*BR_MASK_W +: BR_MASK_W];
            drop         = br_valid_i & br_mispredict_i & (|(dmask & br_mask_i));
            if (br_valid_i && !br_mispredict_i) dmask = dmask & ~br_mask_i;
            if (disp_valid_i[p]) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (!valid_q[e] && erank[e] == pr && !drop) begin
                        valid_d[e] = 1'b1;
                        ent_d[e]   = pkt;
                        mask_d[e]  = dmask;
                        age_d[e]   = older;
                        older[e]   = 1'b1;
                    end
                end
                pr++;
            end
        end

        free_cnt_d = CNT_W'(DEPTH) - CNT_W'($countones(valid_d));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            age_q      <= '0;
            free_cnt_q <= CNT_W'(DEPTH);
            for (int e = 0; e < DEPTH; e++) begin
                ent_q[e]  <= '0;
                mask_q[e] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            age_q      <= age_d;
            free_cnt_q <= free_cnt_d;
            for (int e = 0; e < DEPTH; e++) begin
                ent_q[e]  <= ent_d[e];
                mask_q[e] <= mask_d[e];
            end
        end
    end

    assign free_slots_o = free_cnt_q;

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        $countones(disp_valid_i) <= int'(free_cnt_q));

endmodule

// File: tb/tb_rs_bank.sv
// tb/tb_rs_bank.sv - directed self-checking bench for rs_bank
`timescale 1ns/1ps
module tb_rs_bank;
    import rs_bank_pkg::*;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [1:0]           disp_valid;
    logic [2*ENTRY_W-1:0] disp_pkt;
    logic [7:0]           disp_br_mask;
    logic [4:0]           free_slots;
    logic [1:0]           cdb_valid;
    logic [13:0]          cdb_tag;
    logic [1:0]           issue_valid;
    logic [2*ENTRY_W-1:0] issue_pkt;
    logic [1:0]           issue_ready;
    logic                 br_valid;
    logic [3:0]           br_mask;
    logic                 br_mispredict;

    int n_checks = 0;
    int n_fail   = 0;

    rs_entry_t ip0, ip1;
    assign ip0 = issue_pkt[ENTRY_W-1:0];
    assign ip1 = issue_pkt[2*ENTRY_W-1:ENTRY_W];

`ifdef RS_CDB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    rs_bank dut (
        .clock           (clock),
        .reset           (reset),
        .disp_valid_i    (disp_valid),
        .disp_pkt_i      (disp_pkt),
        .disp_br_mask_i  (disp_br_mask),
        .free_slots_o    (free_slots),
        .cdb_valid_i     (cdb_valid),
        .cdb_tag_i       (cdb_tag),
        .issue_valid_o   (issue_valid),
        .issue_pkt_o     (issue_pkt),
        .issue_ready_i   (issue_ready),
        .br_valid_i      (br_valid),
        .br_mask_i       (br_mask),
        .br_mispredict_i (br_mispredict)
    );

    always #10 clock = ~clock;

    function automatic rs_entry_t mk(input logic [6:0] s1, input logic r1,
                                     input logic [6:0] s2, input logic r2,
                                     input logic [6:0] dest, input logic [5:0] rob);
        rs_entry_t p;
        p.src1_tag = s1;  p.src1_rdy = r1;
        p.src2_tag = s2;  p.src2_rdy = r2;
        p.dest_tag = dest; p.rob_idx = rob;
        p.fu_type  = FU_ALU;
        return p;
    endfunction

    task automatic idle();
        disp_valid = '0; disp_pkt = '0; disp_br_mask = '0;
        cdb_valid = '0; cdb_tag = '0; issue_ready = '0;
        br_valid = 1'b0; br_mask = '0; br_mispredict = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick(); tick(); #1;
        n_checks++; if (issue_valid !== 2'b00) begin n_fail++; $display("FAIL reset_issue_valid: got %b expected 00", issue_valid); end
        n_checks++; if (free_slots !== 5'd16) begin n_fail++; $display("FAIL reset_free_slots: got %0d expected 16", free_slots); end
        n_checks++; if (issue_pkt !== '0) begin n_fail++; $display("FAIL reset_issue_pkt: got %h expected 0", issue_pkt); end
        reset = 1'b1;
    endtask

    task automatic test_dual_issue();
        rs_entry_t p0, p1;
        do_reset();
        p0 = mk(7'd5, 1'b1, 7'd6, 1'b1, 7'd10, 6'd1);
        p1 = mk(7'd6, 1'b1, 7'd5, 1'b1, 7'd11, 6'd2);
        disp_valid = 2'b11; disp_pkt = {p1, p0}; issue_ready = 2'b11; #1;
        n_checks++; if (issue_valid !== 2'b00) begin n_fail++; $display("FAIL dual_pre_valid: got %b expected 00", issue_valid); end
        tick();
        disp_valid = 2'b00; #1;
        n_checks++; if (issue_valid !== 2'b11) begin n_fail++; $display("FAIL dual_valid: got %b expected 11", issue_valid); end
        n_checks++; if (ip0 !== p0) begin n_fail++; $display("FAIL dual_port0_pkt: got %h expected %h", ip0, p0); end
        n_checks++; if (ip1 !== p1) begin n_fail++; $display("FAIL dual_port1_pkt: got %h expected %h", ip1, p1); end
        n_checks++; if (free_slots !== 5'd14) begin n_fail++; $display("FAIL dual_free_mid: got %0d expected 14", free_slots); end
        tick(); #1;
        n_checks++; if (free_slots !== 5'd16) begin n_fail++; $display("FAIL dual_free_after: got %0d expected 16", free_slots); end
        n_checks++; if (issue_valid !== 2'b00) begin n_fail++; $display("FAIL dual_valid_after: got %b expected 00", issue_valid); end
        idle();
    endtask

    task automatic test_wakeup();
        do_reset();
        disp_valid = 2'b01; disp_pkt = {rs_entry_t'('0), mk(7'd42, 1'b0, 7'd3, 1'b1, 7'd12, 6'd3)};
        issue_ready = 2'b01;
        tick();
        disp_valid = 2'b00; #1;
        n_checks++; if (issue_valid !== 2'b00) begin n_fail++; $display("FAIL wake_wait: got %b expected 00", issue_valid); end
        cdb_valid = 2'b01; cdb_tag = {7'd0, 7'd42}; #1;
        n_checks++; if (issue_valid !== {1'b0, BYPASS}) begin n_fail++; $display("FAIL wake_cdb_cycle: got %b expected %b", issue_valid, {1'b0, BYPASS}); end
`ifdef RS_CDB_BYPASS_EN
        n_checks++; if (ip0.dest_tag !== 7'd12) begin n_fail++; $display("FAIL wake_dest: got %0d expected 12", ip0.dest_tag); end
`endif
        tick();
        cdb_valid = 2'b00; #1;
        n_checks++; if (issue_valid !== {1'b0, ~BYPASS}) begin n_fail++; $display("FAIL wake_next_cycle: got %b expected %b", issue_valid, {1'b0, ~BYPASS}); end
`ifndef RS_CDB_BYPASS_EN
        n_checks++; if (ip0.dest_tag !== 7'd12) begin n_fail++; $display("FAIL wake_dest: got %0d expected 12", ip0.dest_tag); end
`endif
        tick(); #1;
        n_checks++; if (free_slots !== 5'd16) begin n_fail++; $display("FAIL wake_free: got %0d expected 16", free_slots); end
        idle();
    endtask

    task automatic test_dispatch_capture();
        do_reset();
        disp_valid = 2'b01; disp_pkt = {rs_entry_t'('0), mk(7'd7, 1'b0, 7'd8, 1'b1, 7'd13, 6'd4)};
        cdb_valid = 2'b10; cdb_tag = {7'd7, 7'd0}; issue_ready = 2'b01;
        tick();
        disp_valid = 2'b00; cdb_valid = 2'b00; #1;
        n_checks++; if (issue_valid !== 2'b01) begin n_fail++; $display("FAIL capture_valid: got %b expected 01", issue_valid); end
        n_checks++; if (ip0.src1_rdy !== 1'b1) begin n_fail++; $display("FAIL capture_src1_rdy: got %b expected 1", ip0.src1_rdy); end
        n_checks++; if (ip0.dest_tag !== 7'd13) begin n_fail++; $display("FAIL capture_dest: got %0d expected 13", ip0.dest_tag); end
        tick(); #1;
        n_checks++; if (free_slots !== 5'd16) begin n_fail++; $display("FAIL capture_free: got %0d expected 16", free_slots); end
        idle();
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            disp_valid = 2'b11;
            disp_pkt = {mk(7'd1, 1'b1, 7'd2, 1'b1, 7'(2*c+1), 6'(2*c+1)),
                        mk(7'd1, 1'b1, 7'd2, 1'b1, 7'(2*c),   6'(2*c))};
            #1;
            n_checks++; if (free_slots !== 5'(16 - 2*c)) begin n_fail++; $display("FAIL fill_free_%0d: got %0d expected %0d", c, free_slots, 16 - 2*c); end
            tick();
        end
        disp_valid = 2'b00;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_checks++; if (free_slots !== 5'd0) begin n_fail++; $display("FAIL stall_free_%0d: got %0d expected 0", s, free_slots); end
            n_checks++; if (issue_valid !== 2'b11) begin n_fail++; $display("FAIL stall_valid_%0d: got %b expected 11", s, issue_valid); end
            n_checks++; if (ip0.dest_tag !== 7'd0 || ip1.dest_tag !== 7'd1) begin n_fail++; $display("FAIL stall_oldest_%0d: got %0d/%0d expected 0/1", s, ip0.dest_tag, ip1.dest_tag); end
            tick();
        end
        issue_ready = 2'b11;
        tick();
        issue_ready = 2'b00; #1;
        n_checks++; if (ip0.dest_tag !== 7'd2 || ip1.dest_tag !== 7'd3) begin n_fail++; $display("FAIL rerank_dest: got %0d/%0d expected 2/3", ip0.dest_tag, ip1.dest_tag); end
        n_checks++; if (free_slots !== 5'd2) begin n_fail++; $display("FAIL rerank_free: got %0d expected 2", free_slots); end
        idle();
    endtask

    task automatic test_squash();
        do_reset();
        disp_valid = 2'b11;
        disp_pkt = {mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd21, 6'd21), mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd20, 6'd20)};
        disp_br_mask = {4'b0010, 4'b0001};
        tick();
        disp_valid = 2'b01;
        disp_pkt = {rs_entry_t'('0), mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd22, 6'd22)};
        disp_br_mask = {4'b0000, 4'b0011};
        tick();
        disp_valid = 2'b00; disp_br_mask = '0;
        br_valid = 1'b1; br_mispredict = 1'b1; br_mask = 4'b0001; #1;
        n_checks++; if (free_slots !== 5'd13) begin n_fail++; $display("FAIL squash_free_before: got %0d expected 13", free_slots); end
        n_checks++; if (issue_valid !== 2'b10) begin n_fail++; $display("FAIL squash_suppress: got %b expected 10", issue_valid); end
        n_checks++; if (ip1.dest_tag !== 7'd21) begin n_fail++; $display("FAIL squash_port1_dest: got %0d expected 21", ip1.dest_tag); end
        tick();
        br_mask = 4'b0100;
        disp_valid = 2'b11;
        disp_pkt = {mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd31, 6'd31), mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd30, 6'd30)};
        disp_br_mask = {4'b1000, 4'b0100};
        #1;
        n_checks++; if (free_slots !== 5'd15) begin n_fail++; $display("FAIL squash_free_after: got %0d expected 15", free_slots); end
        n_checks++; if (issue_valid !== 2'b01 || ip0.dest_tag !== 7'd21) begin n_fail++; $display("FAIL squash_retained: got %b/%0d expected 01/21", issue_valid, ip0.dest_tag); end
        tick();
        idle(); #1;
        n_checks++; if (free_slots !== 5'd14) begin n_fail++; $display("FAIL drop_free: got %0d expected 14", free_slots); end
        n_checks++; if (issue_valid !== 2'b11 || ip1.dest_tag !== 7'd31) begin n_fail++; $display("FAIL drop_kept_port1: got %b/%0d expected 11/31", issue_valid, ip1.dest_tag); end
        idle();
    endtask

    task automatic test_resolve();
        do_reset();
        disp_valid = 2'b01;
        disp_pkt = {rs_entry_t'('0), mk(7'd50, 1'b0, 7'd2, 1'b1, 7'd40, 6'd40)};
        disp_br_mask = {4'b0000, 4'b0010};
        tick();
        disp_pkt = {rs_entry_t'('0), mk(7'd50, 1'b0, 7'd2, 1'b1, 7'd41, 6'd41)};
        disp_br_mask = {4'b0000, 4'b0011};
        br_valid = 1'b1; br_mispredict = 1'b0; br_mask = 4'b0010;
        tick();
        disp_valid = 2'b00; disp_br_mask = '0;
        br_mispredict = 1'b1; br_mask = 4'b0010; #1;
        n_checks++; if (free_slots !== 5'd14) begin n_fail++; $display("FAIL resolve_free_pre: got %0d expected 14", free_slots); end
        tick();
        br_mask = 4'b0001; #1;
        n_checks++; if (free_slots !== 5'd14) begin n_fail++; $display("FAIL resolve_kept: got %0d expected 14", free_slots); end
        tick();
        idle(); #1;
        n_checks++; if (free_slots !== 5'd15) begin n_fail++; $display("FAIL resolve_disp_cleared: got %0d expected 15", free_slots); end
        cdb_valid = 2'b01; cdb_tag = {7'd0, 7'd50};
        tick();
        cdb_valid = 2'b00; #1;
        n_checks++; if (issue_valid !== 2'b01 || ip0.dest_tag !== 7'd40) begin n_fail++; $display("FAIL resolve_survivor: got %b/%0d expected 01/40", issue_valid, ip0.dest_tag); end
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        disp_valid = 2'b11;
        disp_pkt = {mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd61, 6'd1), mk(7'd1, 1'b1, 7'd2, 1'b1, 7'd60, 6'd0)};
        tick();
        disp_valid = 2'b00; #1;
        n_checks++; if (free_slots !== 5'd14) begin n_fail++; $display("FAIL async_pre_free: got %0d expected 14", free_slots); end
        #3 reset = 1'b0;
        #1;
        n_checks++; if (free_slots !== 5'd16) begin n_fail++; $display("FAIL async_free: got %0d expected 16", free_slots); end
        n_checks++; if (issue_valid !== 2'b00) begin n_fail++; $display("FAIL async_valid: got %b expected 00", issue_valid); end
        n_checks++; if (issue_pkt !== '0) begin n_fail++; $display("FAIL async_pkt: got %h expected 0", issue_pkt); end
        tick();
        reset = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_dual_issue();
        test_wakeup();
        test_dispatch_capture();
        test_full_stall();
        test_squash();
        test_resolve();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
